dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the CPU's MEM-stage data-access interface. Accepts one load/store request at a time, stalls the pipeline via `busywait` for a programmable number of cycles, and then completes the access. Backing store is a word-organised RAM with byte enables, plus two memory-mapped registers: the LED output register and a free-running cycle counter. Sits between the MEM stage and the board LEDs, replacing direct single-cycle memory.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words (power of two); RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- `LATENCY`, 2: stall cycles per access, legal range 1..15.
- `LED_ADDR`, 32'h0000_F000: LED register byte address (word-aligned).
- `CNT_ADDR`, 32'h0000_F004: cycle-counter byte address (read-only).
- `clk`  in  1  system clock.
- `reset`  in  1  reset; one clock, asynchronous, active-high.
- `read_write`  in  4  request code: 0000 idle; 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU; 0001 SB, 0010 SH, 0011 SW; other codes treated as idle.
- `address`  in  32  byte address, held stable while `busywait`=1.
- `D_in`  in  32  store data (low byte/half used for SB/SH), held stable while `busywait`=1.
- `D_out`  out  32  load result, sign/zero-extended; valid only in the completion cycle, 0 otherwise.
- `busywait`  out  1  pipeline stall request.
- `led`  out  15  LED register contents.
- `err`  out  1  sticky: misaligned or unmapped access seen.

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`.
- IDLE: `busywait` = (read_write is a legal non-idle code), combinational. On such a request: capture request, read addressed RAM word into a data register, `cnt` <= LATENCY-1, go BUSY.
- BUSY, cnt != 0: `busywait`=1, cnt decrements.
- BUSY, cnt == 0 (completion cycle): `busywait`=0; loads drive `D_out`; stores commit at the closing edge; next state IDLE.
- Loads: byte lane = address[1:0], half lane = address[1]; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores: byte enables from size and address[1:0]; SB writes D_in[7:0], SH writes D_in[15:0] to the selected lane.
- Alignment: LH/LHU/SH require address[0]=0; LW/SW require address[1:0]=0. Misaligned: store dropped, load returns 0, `err` set. Full latency still applies.
- LED_ADDR: store writes `led` with byte enables applied to bits [14:0] (SB updates led[7:0] only); load returns {17'b0, led}.
- CNT_ADDR: 32-bit counter, +1 every cycle, wraps at 2^32-1 → 0. Load returns the value sampled at request acceptance. Stores are ignored and set `err`.
- Unmapped address: store dropped, load returns 0, `err` set.
- Reset values: state IDLE, cnt 0, `D_out` 0, `led` 0, `err` 0, counter 0. RAM contents are not reset.
- Reset during BUSY: the access is abandoned and a pending store is never committed. After reset deasserts, a request still present on the inputs is accepted as new.

## Timing
- Request presented in cycle 0 → `busywait` high in cycles 0..LATENCY-1 → completion in cycle LATENCY. Total stall is exactly LATENCY cycles.
- The CPU advances on the edge that ends the completion cycle. A request visible in the following IDLE cycle is a new access, including one identical to the previous request.
- Back-to-back requests: next access begins in cycle LATENCY+1, with no idle bubble beyond that.
- Store-then-load to the same word: the load reads the RAM in its acceptance cycle, which is after the store's commit edge, so it returns the new data.

## Structure
- Package `dmem_pkg`: read_write code constants, state enum, size/sign decode helpers, default MMIO addresses.
- Sub-module `dmem_ram`: synchronous DEPTH_WORDS×32 RAM, 4 byte-write enables, registered read, no reset.
- Top contains FSM, lane/extension logic, MMIO decode, counter, `led`/`err` registers.

## Test plan
- LATENCY=2. SW 0xDEADBEEF to 0x10, then LW 0x10 → `busywait` high exactly 2 cycles per access; D_out=0xDEADBEEF in the completion cycle, 0 otherwise.
- After the above: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF; SB 0x55 to 0x11 then LW 0x10 → 0xDEAD55EF.
- SW 0x0000FFFF to LED_ADDR → led=0x7FFF; SB 0x00 to LED_ADDR → led=0x7F00; LW LED_ADDR → 0x00007F00.
- LW 0x12 (misaligned) → D_out 0, err=1, RAM unchanged. SW to 0x8000_0000 → no write, err remains 1 until reset.
- Reset asserted mid-BUSY of SW 0x1234 to 0x20 → busywait and FSM return to IDLE immediately; a later LW 0x20 does not return 0x1234. Two LW CNT_ADDR 10 cycles apart → values differ by 10.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: request codes, FSM states, decode helpers and default MMIO addresses for dmem_responder
package dmem_pkg;
    localparam logic [3:0] RW_IDLE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b1000;
    localparam logic [3:0] RW_LH   = 4'b1001;
    localparam logic [3:0] RW_LW   = 4'b1010;
    localparam logic [3:0] RW_LBU  = 4'b1100;
    localparam logic [3:0] RW_LHU  = 4'b1101;
    localparam logic [3:0] RW_SB   = 4'b0001;
    localparam logic [3:0] RW_SH   = 4'b0010;
    localparam logic [3:0] RW_SW   = 4'b0011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] LED_ADDR_DEF = 32'h0000_F000;
    localparam logic [31:0] CNT_ADDR_DEF = 32'h0000_F004;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic rw_legal(input logic [3:0] rw);
        return rw inside {RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU, RW_SB, RW_SH, RW_SW};
    endfunction

    function automatic logic [1:0] rw_size(input logic [3:0] rw);
        return rw[3] ? rw[1:0] : rw[1:0] - 2'd1;
    endfunction

    function automatic logic rw_signed(input logic [3:0] rw);
        return !rw[2];
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-organised synchronous RAM with byte write enables and registered read
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[addr];
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle MEM-stage data responder with RAM, LED register and cycle counter
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
    parameter logic [31:0] CNT_ADDR    = CNT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  read_write,
    input  logic [31:0] address,
    input  logic [31:0] D_in,
    output logic [31:0] D_out,
    output logic        busywait,
    output logic [14:0] led,
    output logic        err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t      state, state_n;
    logic [3:0]  cnt, rq_rw, be, ram_we;
    logic [31:0] rq_addr, rq_din, cnt_cap, cycles, ram_q, rword, wdata, ld_val;
    logic [1:0]  sz;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [14:0] led_mask;
    logic        accept, done, is_ld, sg, in_ram, is_led, is_cnt, aligned, ok, st_ok;

    assign accept   = state == IDLE && rw_legal(read_write);
    assign done     = state == BUSY && cnt == 4'd0;
    assign busywait = state == IDLE ? rw_legal(read_write) : cnt != 4'd0;

    always_comb state_n = accept ? BUSY : done ? IDLE : state;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    assign sz       = rw_size(rq_rw);
    assign is_ld    = rq_rw[3];
    assign sg       = rw_signed(rq_rw);
    assign in_ram   = rq_addr[31:AW+2] == '0;
    assign is_led   = rq_addr[31:2] == LED_ADDR[31:2];
    assign is_cnt   = rq_addr[31:2] == CNT_ADDR[31:2];
    assign aligned  = sz == SZ_W ? rq_addr[1:0] == 2'b00 : sz == SZ_H ? !rq_addr[0] : 1'b1;
    assign ok       = aligned && (in_ram || is_led || is_cnt) && !(is_cnt && !is_ld);
    assign st_ok    = done && !is_ld && ok;
    assign be       = sz == SZ_W ? 4'hF : sz == SZ_H ? (rq_addr[1] ? 4'hC : 4'h3) : 4'b0001 << rq_addr[1:0];
    assign wdata    = sz == SZ_W ? rq_din : sz == SZ_H ? {2{rq_din[15:0]}} : {4{rq_din[7:0]}};
    assign led_mask = {{7{be[1]}}, {8{be[0]}}};
    assign ram_we   = st_ok && in_ram ? be : 4'b0000;

    assign rword  = is_led ? {17'b0, led} : is_cnt ? cnt_cap : ram_q;
    assign byte_v = rword[{rq_addr[1:0], 3'b000} +: 8];
    assign half_v = rword[{rq_addr[1], 4'b0000} +: 16];
    assign ld_val = sz == SZ_B ? {{24{sg & byte_v[7]}}, byte_v}
                  : sz == SZ_H ? {{16{sg & half_v[15]}}, half_v} : rword;
    assign D_out  = done && is_ld && ok ? ld_val : '0;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk  (clk),
        .re   (accept),
        .we   (ram_we),
        .addr (state == IDLE ? address[AW+1:2] : rq_addr[AW+1:2]),
        .wdata(wdata),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            rq_rw   <= RW_IDLE;
            rq_addr <= '0;
            rq_din  <= '0;
            cnt_cap <= '0;
            cycles  <= '0;
            led     <= '0;
            err     <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                rq_rw   <= read_write;
                rq_addr <= address;
                rq_din  <= D_in;
                cnt_cap <= cycles;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (done && !ok) err <= 1'b1;
            if (st_ok && is_led) led <= (wdata[14:0] & led_mask) | (led & ~led_mask);
        end
    end
endmodule
